// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Opcode constants, fetch FSM state encoding and length width
//               shared by the instruction fetch unit and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int LEN_W = 3;

    localparam logic [7:0] OP_PUSH_EBP    = 8'h55;
    localparam logic [7:0] OP_MOV_RM      = 8'h89;
    localparam logic [7:0] OP_MOV_EAX_IMM = 8'hb8;
    localparam logic [7:0] OP_POP_EBP     = 8'h5d;
    localparam logic [7:0] OP_RET         = 8'hc3;
    localparam logic [7:0] OP_CALL_REL    = 8'he8;

    typedef enum logic [1:0] {
        FETCH0 = 2'd0,
        FETCH1 = 2'd1,
        HOLD   = 2'd2,
        HALT   = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/insn_length_decode.sv
// ============================================================================
// Module      : insn_length_decode
// Description : Combinational opcode-to-length lookup; known flags opcodes
//               the fetch unit understands (length 0 when unknown).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module insn_length_decode
    import fetch_pkg::*;
(
    input  logic [7:0]       opcode,
    output logic [LEN_W-1:0] length,
    output logic             known
);

    always_comb begin
        length = '0;
        known  = 1'b0;
        case (opcode)
            OP_PUSH_EBP, OP_POP_EBP, OP_RET: begin
                length = LEN_W'(1);
                known  = 1'b1;
            end
            OP_MOV_RM: begin
                length = LEN_W'(2);
                known  = 1'b1;
            end
            OP_MOV_EAX_IMM, OP_CALL_REL: begin
                length = LEN_W'(5);
                known  = 1'b1;
            end
            default: begin
                length = '0;
                known  = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : Variable-length (1/2/5 byte) instruction fetch over a 32-bit
//               combinational memory port with valid/ready issue and redirect.
//               Macro ILLEGAL_TRAP_EN: unknown opcodes halt and raise illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  mem_addr,
    input  logic [31:0] mem_ope,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [7:0]  inst_opcode,
    output logic [31:0] inst_imm,
    output logic [2:0]  inst_len,
    output logic [7:0]  inst_pc,
    output logic        illegal
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [7:0]       r_pc;
    logic [7:0]       w_pc_next;
    logic [7:0]       r_opcode;
    logic [7:0]       w_opcode_next;
    logic [31:0]      r_imm;
    logic [31:0]      w_imm_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_next;
    logic [7:0]       r_inst_pc;
    logic [7:0]       w_inst_pc_next;

    logic [LEN_W-1:0] w_dec_len;
    logic             w_dec_known;
    logic [LEN_W-1:0] w_len_eff;
    logic             w_trap;

    insn_length_decode u_decode (
        .opcode (mem_ope[31:24]),
        .length (w_dec_len),
        .known  (w_dec_known)
    );

    // Unknown opcodes fall back to single-byte issue when not trapped.
    assign w_len_eff = w_dec_known ? w_dec_len : LEN_W'(1);

`ifdef ILLEGAL_TRAP_EN
    assign w_trap = ~w_dec_known;
`else
    assign w_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= FETCH0;
            r_pc      <= RESET_PC;
            r_opcode  <= 8'h00;
            r_imm     <= 32'h0;
            r_len     <= '0;
            r_inst_pc <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_opcode  <= w_opcode_next;
            r_imm     <= w_imm_next;
            r_len     <= w_len_next;
            r_inst_pc <= w_inst_pc_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_opcode_next  = r_opcode;
        w_imm_next     = r_imm;
        w_len_next     = r_len;
        w_inst_pc_next = r_inst_pc;

        if (redirect) begin
            // A redirect coinciding with a handshake still consumes the
            // held instruction; the pc simply comes from the jump target.
            w_state_next = FETCH0;
            w_pc_next    = redirect_addr;
        end else begin
            case (r_state)
                FETCH0: begin
                    w_opcode_next  = mem_ope[31:24];
                    w_inst_pc_next = r_pc;
                    if (w_trap) begin
                        w_imm_next   = 32'h0;
                        w_len_next   = '0;
                        w_state_next = HALT;
                    end else begin
                        w_len_next = w_len_eff;
                        case (w_len_eff)
                            LEN_W'(2): begin
                                w_imm_next   = {24'h0, mem_ope[23:16]};
                                w_state_next = HOLD;
                            end
                            LEN_W'(5): begin
                                // Bytes 1..3 now; byte 4 arrives in FETCH1.
                                w_imm_next   = {8'h00, mem_ope[7:0],
                                                mem_ope[15:8], mem_ope[23:16]};
                                w_state_next = FETCH1;
                            end
                            default: begin
                                w_imm_next   = 32'h0;
                                w_state_next = HOLD;
                            end
                        endcase
                    end
                end
                FETCH1: begin
                    w_imm_next   = {mem_ope[31:24], r_imm[23:0]};
                    w_state_next = HOLD;
                end
                HOLD: begin
                    if (inst_ready) begin
                        w_pc_next    = r_pc + {{(8-LEN_W){1'b0}}, r_len};
                        w_state_next = FETCH0;
                    end
                end
                HALT: begin
                    w_state_next = HALT;
                end
                default: begin
                    w_state_next = FETCH0;
                end
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else if (redirect) begin
            r_illegal <= 1'b0;
        end else if (r_state == FETCH0 && w_trap) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // The immediate's top byte sits at pc+4, which may wrap past 8'hff.
    assign mem_addr    = (r_state == FETCH1) ? (r_pc + 8'd4) : r_pc;
    assign inst_valid  = (r_state == HOLD);
    assign inst_opcode = r_opcode;
    assign inst_imm    = r_imm;
    assign inst_len    = r_len;
    assign inst_pc     = r_inst_pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch: directed vector
//               table, multi-cycle corner sequences and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [7:0]  mem_addr;
    logic [31:0] mem_ope;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  inst_opcode;
    logic [31:0] inst_imm;
    logic [2:0]  inst_len;
    logic [7:0]  inst_pc;
    logic        illegal;

    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.RESET_PC(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_ope       (mem_ope),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_opcode   (inst_opcode),
        .inst_imm      (inst_imm),
        .inst_len      (inst_len),
        .inst_pc       (inst_pc),
        .illegal       (illegal)
    );

    assign mem_ope = {mem[mem_addr], mem[mem_addr + 8'd1],
                      mem[mem_addr + 8'd2], mem[mem_addr + 8'd3]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: instruction architecture straight from the opcode table.
    function automatic int ref_len(input logic [7:0] op);
        case (op)
            8'h55, 8'h5d, 8'hc3: return 1;
            8'h89:               return 2;
            8'hb8, 8'he8:        return 5;
            default:             return 1;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [7:0] pc);
        int n;
        n = ref_len(mem[pc]);
        if (n == 2) return {24'h0, mem[pc + 8'd1]};
        if (n == 5) return {mem[pc + 8'd4], mem[pc + 8'd3], mem[pc + 8'd2], mem[pc + 8'd1]};
        return 32'h0;
    endfunction

    task automatic wait_valid(input string name, output int cyc);
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (inst_valid) return;
        end
        chk({name, "_timeout"}, 32'(inst_valid), 32'h1);
    endtask

    task automatic goto_addr(input logic [7:0] a);
        redirect      = 1'b1;
        redirect_addr = a;
        @(negedge clk);
        redirect      = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h00);
        chk({tag, "_valid"},    32'(inst_valid), 32'h0);
        chk({tag, "_opcode"},   32'(inst_opcode), 32'h0);
        chk({tag, "_imm"},      inst_imm, 32'h0);
        chk({tag, "_len"},      32'(inst_len), 32'h0);
        chk({tag, "_pc"},       32'(inst_pc), 32'h0);
        chk({tag, "_illegal"},  32'(illegal), 32'h0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] imm;
        logic [2:0]  len;
        logic [7:0]  pc;
        int          gap;
    } vec_t;

    vec_t vecs [5];

    logic [7:0] pool [7];

    initial begin
        int cyc;
        logic [7:0] mpc;
        logic [7:0] jaddr;
        logic       rdy;
        logic       rdr;
        int         idle;

        vecs[0] = '{8'h55, 32'h0000_0000, 3'd1, 8'h00, 0};
        vecs[1] = '{8'h89, 32'h0000_00e5, 3'd2, 8'h01, 2};
        vecs[2] = '{8'hb8, 32'h0000_0002, 3'd5, 8'h03, 3};
        vecs[3] = '{8'h5d, 32'h0000_0000, 3'd1, 8'h08, 2};
        vecs[4] = '{8'hc3, 32'h0000_0000, 3'd1, 8'h09, 2};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h55; mem[1] = 8'h89; mem[2] = 8'he5; mem[3] = 8'hb8;
        mem[4] = 8'h02; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h00;
        mem[8] = 8'h5d; mem[9] = 8'hc3;

        redirect = 1'b0; redirect_addr = 8'h00; inst_ready = 1'b1;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 chk_reset_outputs("por");
        @(negedge clk);
        chk_reset_outputs("por_hold");
        reset = 1'b1;

        // Straight-line program with a consumer that is always ready.
        for (int i = 0; i < 5; i++) begin
            wait_valid("prog", cyc);
            chk($sformatf("prog%0d_opcode", i), 32'(inst_opcode), 32'(vecs[i].op));
            chk($sformatf("prog%0d_imm", i),    inst_imm, vecs[i].imm);
            chk($sformatf("prog%0d_len", i),    32'(inst_len), 32'(vecs[i].len));
            chk($sformatf("prog%0d_pc", i),     32'(inst_pc), 32'(vecs[i].pc));
            if (i == 0) chk("first_fetch_latency", 32'(cyc), 32'd1);
            else        chk($sformatf("prog%0d_interval", i), 32'(cyc), 32'(vecs[i].gap));
        end

        // Back-pressure holds the instruction unchanged.
        mem[8'h20] = 8'h89; mem[8'h21] = 8'he5;
        inst_ready = 1'b0;
        goto_addr(8'h20);
        wait_valid("stall", cyc);
        for (int k = 0; k < 6; k++) begin
            chk("stall_valid",  32'(inst_valid), 32'h1);
            chk("stall_opcode", 32'(inst_opcode), 32'h89);
            chk("stall_imm",    inst_imm, 32'h0000_00e5);
            chk("stall_len",    32'(inst_len), 32'h2);
            chk("stall_pc",     32'(inst_pc), 32'h20);
            chk("stall_addr",   32'(mem_addr), 32'h20);
            if (k < 5) @(negedge clk);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", 32'(inst_valid), 32'h0);
        chk("stall_release_addr",  32'(mem_addr), 32'h22);

        // Redirect in the same cycle as a handshake.
        mem[8'h30] = 8'h55; mem[8'h40] = 8'h5d;
        inst_ready = 1'b0;
        goto_addr(8'h30);
        wait_valid("rdhs", cyc);
        chk("rdhs_opcode", 32'(inst_opcode), 32'h55);
        inst_ready = 1'b1;
        goto_addr(8'h40);
        chk("rdhs_valid_drop", 32'(inst_valid), 32'h0);
        chk("rdhs_addr",       32'(mem_addr), 32'h40);
        wait_valid("rdhs_next", cyc);
        chk("rdhs_next_opcode", 32'(inst_opcode), 32'h5d);
        chk("rdhs_next_pc",     32'(inst_pc), 32'h40);

        // Unknown opcode.
        mem[8'h10] = 8'h0f;
        goto_addr(8'h10);
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("trap_illegal", 32'(illegal), 32'h1);
            chk("trap_pc",      32'(inst_pc), 32'h10);
            chk("trap_valid",   32'(inst_valid), 32'h0);
        end
        goto_addr(8'h20);
        chk("trap_clear", 32'(illegal), 32'h0);
`else
        wait_valid("unk", cyc);
        chk("unk_opcode",  32'(inst_opcode), 32'h0f);
        chk("unk_len",     32'(inst_len), 32'h1);
        chk("unk_imm",     inst_imm, 32'h0);
        chk("unk_pc",      32'(inst_pc), 32'h10);
        chk("unk_illegal", 32'(illegal), 32'h0);
        @(negedge clk);
        chk("unk_next_addr", 32'(mem_addr), 32'h11);
`endif

        // Five-byte instruction wrapping the address space.
        mem[8'hfe] = 8'hb8; mem[8'hff] = 8'h11; mem[8'h00] = 8'h22;
        mem[8'h01] = 8'h33; mem[8'h02] = 8'h44;
        goto_addr(8'hfe);
        chk("wrap_fetch0_addr", 32'(mem_addr), 32'hfe);
        @(negedge clk);
        chk("wrap_fetch1_addr",  32'(mem_addr), 32'h02);
        chk("wrap_fetch1_valid", 32'(inst_valid), 32'h0);
        @(negedge clk);
        chk("wrap_valid",  32'(inst_valid), 32'h1);
        chk("wrap_opcode", 32'(inst_opcode), 32'hb8);
        chk("wrap_imm",    inst_imm, 32'h4433_2211);
        chk("wrap_len",    32'(inst_len), 32'h5);
        chk("wrap_pc",     32'(inst_pc), 32'hfe);
        @(negedge clk);
        chk("wrap_next_addr", 32'(mem_addr), 32'h03);

        // Asynchronous reset in the middle of a five-byte fetch.
        mem[0] = 8'h55; mem[1] = 8'h89; mem[2] = 8'he5;
        mem[8'h50] = 8'hb8;
        goto_addr(8'h50);
        @(negedge clk);
        chk("mid_fetch1_addr", 32'(mem_addr), 32'h54);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("async");
        @(negedge clk);
        reset = 1'b1;
        wait_valid("restart", cyc);
        chk("restart_latency", 32'(cyc), 32'd1);
        chk("restart_opcode",  32'(inst_opcode), 32'h55);
        chk("restart_pc",      32'(inst_pc), 32'h00);

        // Randomized traffic against the instruction-level model.
        pool[0] = 8'h55; pool[1] = 8'h5d; pool[2] = 8'hc3; pool[3] = 8'h89;
        pool[4] = 8'hb8; pool[5] = 8'he8;
`ifdef ILLEGAL_TRAP_EN
        pool[6] = 8'h89;
`else
        pool[6] = 8'h0f;
`endif
        for (int i = 0; i < 256; i++) mem[i] = pool[$urandom_range(0, 6)];
        jaddr = 8'($urandom);
        goto_addr(jaddr);
        mpc  = jaddr;
        idle = 0;
        for (int n = 0; n < 3000; n++) begin
            if (inst_valid) begin
                idle = 0;
                chk("rnd_opcode",  32'(inst_opcode), 32'(mem[mpc]));
                chk("rnd_imm",     inst_imm, ref_imm(mpc));
                chk("rnd_len",     32'(inst_len), 32'(ref_len(mem[mpc])));
                chk("rnd_pc",      32'(inst_pc), 32'(mpc));
                chk("rnd_illegal", 32'(illegal), 32'h0);
            end else begin
                idle++;
                if (idle > 4) begin
                    chk("rnd_progress", 32'(inst_valid), 32'h1);
                    idle = 0;
                end
            end
            rdy   = ($urandom_range(0, 3) != 0);
            rdr   = ($urandom_range(0, 19) == 0);
            jaddr = 8'($urandom);
            if (rdr) mpc = jaddr;
            else if (inst_valid && rdy) mpc = mpc + 8'(ref_len(mem[mpc]));
            inst_ready    = rdy;
            redirect      = rdr;
            redirect_addr = jaddr;
            @(negedge clk);
        end
        redirect = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
